ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter FILTER_LEN, default 8, consecutive equal ps2_clk samples needed to accept a level change.
REQ-003 Parameter TIMEOUT_CYCLES, default 20000, maximum clk100 cycles between ps2_clk falling edges inside a frame (200 us at 100 MHz).
REQ-004 clk100  input  1  sole clock; all logic on its rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 ps2_clk  input  1  asynchronous PS/2 clock from the keyboard, idle high.
REQ-007 ps2_data  input  1  asynchronous PS/2 data from the keyboard, idle high.
REQ-008 rx_data  output  8  last correctly received byte; held until the next good frame.
REQ-009 rx_complete  output  1  one-cycle pulse; rx_data is valid and new in that cycle.
REQ-010 rx_error  output  1  one-cycle pulse on parity error, stop-bit error or timeout.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; shorter pulses SHALL be ignored.
REQ-013 A sample event SHALL occur in the cycle the filtered clock goes 1->0; ps2_data (synchronized) SHALL be captured in that cycle.
REQ-014 Frame format SHALL be 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: sample 0 -> DATA with bit count 0; sample 1 -> remain IDLE, no output.
REQ-017 DATA: each sample shifted into an 8-bit register at bit 7 (shift right); after the 8th sample -> PARITY.
REQ-018 PARITY: sample stored -> STOP.
REQ-019 STOP: if stop sample is 1 and XOR of 8 data bits and parity bit is 1, rx_data SHALL update and rx_complete SHALL pulse in the next cycle; otherwise rx_error SHALL pulse and rx_data SHALL stay unchanged; both cases -> IDLE.
REQ-020 Latency: rx_complete SHALL assert exactly 1 cycle after the stop-bit sample event.
REQ-021 Timeout counter SHALL clear on every sample event and in IDLE; in DATA/PARITY/STOP reaching TIMEOUT_CYCLES SHALL force IDLE and pulse rx_error once.
REQ-022 Timeout counter SHALL saturate, never wrap.
REQ-023 rx_complete and rx_error SHALL never be asserted in the same cycle.
REQ-024 Outputs SHALL be registered; no combinational path from ps2 inputs to outputs.
REQ-025 Block SHALL never drive ps2_clk or ps2_data (receive only, no host-to-device).

Reset
REQ-026 With resetn low at a clk100 edge: FSM IDLE, bit count 0, shift register 0, timeout counter 0, filter counter 0.
REQ-027 Synchronizer flops and filtered clock SHALL reset to 1 (bus idle), so no false edge follows reset.
REQ-028 rx_data SHALL reset to 8'h00; rx_complete and rx_error SHALL reset to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without any rx_complete or rx_error pulse.

Structure
REQ-030 Shared package/include SHALL hold PS/2 constants: frame length 11, prefix codes 8'hE0 and 8'hF0, default timing parameters.
REQ-031 One sub-module ps2_input_filter SHALL contain the synchronizers, clock glitch filter and falling-edge detect, outputting sample_strobe and sample_bit.
REQ-032 Frame FSM, parity check and timeout SHALL reside in ps2_rx; interface SHALL stay drop-in compatible with the keyboard consumer (rx_data, rx_complete).

Verification
REQ-033 Frame 0x1C, parity 0, stop 1, 12.5 kHz ps2_clk -> one rx_complete, rx_data=8'h1C, no rx_error.
REQ-034 Back-to-back frames 0xF0 (parity 1) then 0x1C (parity 0) -> two rx_complete pulses, rx_data 8'hF0 then 8'h1C.
REQ-035 Frame 0x1C with parity 1 -> one rx_error, no rx_complete, rx_data keeps previous value.
REQ-036 4-cycle low glitch on ps2_clk while idle and mid-frame -> no sample event; following valid 0x5A (parity 1) received correctly.
REQ-037 Start bit plus 3 data bits, then ps2_clk held high 250 us -> exactly one rx_error at 20000 cycles after last edge; next frame 0x5A -> rx_complete, rx_data=8'h5A.
REQ-038 resetn pulsed low after 5 bits of a frame -> no pulses, all outputs at reset values; next full frame 0x1C received correctly.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// PS/2 receive constants, default timing and frame FSM state encoding.
package ps2_rx_pkg;

    // 11-bit frame: start, 8 data bits LSB first, odd parity, stop
    localparam int unsigned PS2_FRAME_LEN = 11;
    localparam int unsigned PS2_DATA_BITS = PS2_FRAME_LEN - 3;

    // Scan-code prefixes seen by the keyboard consumer
    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    // Default timing: 100 MHz system clock, 200 us inter-edge timeout
    localparam int unsigned DEFAULT_CLK_HZ         = 100_000_000;
    localparam int unsigned DEFAULT_FILTER_LEN     = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 20_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes ps2_clk/ps2_data, glitch-filters the clock and emits one
// sample strobe per filtered falling edge together with the data bit.
//   clk100, resetn      : system clock, synchronous active-low reset
//   ps2_clk, ps2_data   : asynchronous PS/2 lines (idle high)
//   sample_strobe       : one-cycle pulse when the filtered clock falls
//   sample_bit          : synchronized ps2_data captured with the strobe
module ps2_input_filter
    import ps2_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clk100,
    input  logic resetn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sample_strobe,
    output logic sample_bit
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [CW-1:0] filt_cnt;

    // Sync flops and filtered clock come up high so reset release shows no edge
    always_ff @(posedge clk100) begin
        if (!resetn) begin
            clk_sync      <= 2'b11;
            data_sync     <= 2'b11;
            clk_filt      <= 1'b1;
            filt_cnt      <= '0;
            sample_strobe <= 1'b0;
            sample_bit    <= 1'b1;
        end else begin
            clk_sync      <= {clk_sync[0], ps2_clk};
            data_sync     <= {data_sync[0], ps2_data};
            sample_strobe <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
                // FILTER_LEN-th consecutive sample at the new level
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                if (!clk_sync[1]) begin
                    sample_strobe <= 1'b1;
                    sample_bit    <= data_sync[1];
                end
            end else begin
                filt_cnt <= filt_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frames filtered sample events into bytes,
// checks odd parity and stop bit, and aborts stalled frames on timeout.
//   clk100, resetn      : system clock, synchronous active-low reset
//   ps2_clk, ps2_data   : asynchronous PS/2 lines, inputs only
//   rx_data             : last good byte, held until the next good frame
//   rx_complete         : one-cycle pulse, rx_data new in that cycle
//   rx_error            : one-cycle pulse on parity/stop error or timeout
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ         = DEFAULT_CLK_HZ,
    parameter int unsigned FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk100,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_complete,
    output logic       rx_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    // Timeout must outlast one bit period of the slowest (10 kHz) PS/2 clock
    if (TIMEOUT_CYCLES <= CLK_HZ / 10_000) begin : g_bad_timeout
        $error("ps2_rx: TIMEOUT_CYCLES shorter than a 10 kHz PS/2 bit period");
    end

    logic sample_strobe;
    logic sample_bit;

    ps2_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk100        (clk100),
        .resetn        (resetn),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .sample_strobe (sample_strobe),
        .sample_bit    (sample_bit)
    );

    rx_state_t     state,      state_nxt;
    logic [2:0]    bit_cnt,    bit_cnt_nxt;
    logic [7:0]    shift_reg,  shift_nxt;
    logic          parity_bit, parity_nxt;
    logic [TW-1:0] tcnt,       tcnt_nxt;
    logic [7:0]    data_nxt;
    logic          complete_nxt;
    logic          error_nxt;

    // State and output registers
    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            tcnt        <= '0;
            rx_data     <= 8'h00;
            rx_complete <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_reg   <= shift_nxt;
            parity_bit  <= parity_nxt;
            tcnt        <= tcnt_nxt;
            rx_data     <= data_nxt;
            rx_complete <= complete_nxt;
            rx_error    <= error_nxt;
        end
    end

    // Frame sequencing, parity/stop check and timeout
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_reg;
        parity_nxt   = parity_bit;
        data_nxt     = rx_data;
        complete_nxt = 1'b0;
        error_nxt    = 1'b0;

        // Saturating inter-edge counter, idle only while a frame is open
        if (state == ST_IDLE || sample_strobe) begin
            tcnt_nxt = '0;
        end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
            tcnt_nxt = tcnt + TW'(1);
        end else begin
            tcnt_nxt = tcnt;
        end

        case (state)
            ST_IDLE: begin
                if (sample_strobe && !sample_bit) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (sample_strobe) begin
                    shift_nxt   = {sample_bit, shift_reg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'(1);
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_strobe) begin
                    parity_nxt = sample_bit;
                    state_nxt  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_strobe) begin
                    if (sample_bit && odd_parity_ok(shift_reg, parity_bit)) begin
                        data_nxt     = shift_reg;
                        complete_nxt = 1'b1;
                    end else begin
                        error_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Stalled frame: abandon it; counter clears in IDLE so this fires once
        if (state != ST_IDLE && !sample_strobe && tcnt == TW'(TIMEOUT_CYCLES)) begin
            state_nxt = ST_IDLE;
            error_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx. The PS/2 clock is compressed to an 80-cycle
// period so all frames fit in a short run; the timeout keeps its default.
module tb_ps2_rx;

    localparam int HALF = 40;

    logic       clk100 = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_complete;
    logic       rx_error;

    int n_vec  = 0;
    int n_miss = 0;

    int cyc       = 0;
    int comp_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int err_cyc   = 0;
    int last_fall = 0;

    ps2_rx dut (
        .clk100      (clk100),
        .resetn      (resetn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_data     (rx_data),
        .rx_complete (rx_complete),
        .rx_error    (rx_error)
    );

    always #5 clk100 = ~clk100;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk100) begin
        cyc = cyc + 1;
        if (rx_complete) comp_cnt = comp_cnt + 1;
        if (rx_error) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (rx_complete && rx_error) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk100);
    endtask

    // Send the first nbits of a frame; optionally a 4-cycle clock glitch
    // in the high phase after bit glitch_at
    task automatic send_bits(input logic [7:0] d, input logic p, input int nbits,
                             input int glitch_at);
        logic [10:0] fr;
        fr = {1'b1, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(HALF);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            if (i == glitch_at) begin
                wait_cyc(10);
                ps2_clk = 1'b0;
                wait_cyc(4);
                ps2_clk = 1'b1;
            end
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] d, input logic p,
                               input int exp_comp, input int exp_err,
                               input logic [7:0] exp_data, input int glitch_at);
        int c0, e0;
        c0 = comp_cnt;
        e0 = err_cnt;
        send_bits(d, p, 11, glitch_at);
        chk({tag, "_complete"}, 32'(comp_cnt - c0), 32'(exp_comp));
        chk({tag, "_error"},    32'(err_cnt - e0),  32'(exp_err));
        chk({tag, "_data"},     32'(rx_data),       32'(exp_data));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e0, lat;
        resetn   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        chk("reset_data",     32'(rx_data),     32'h00);
        chk("reset_complete", 32'(rx_complete), 32'h0);
        chk("reset_error",    32'(rx_error),    32'h0);
        resetn = 1'b1;
        wait_cyc(20);

        // Single good frame
        frame_check("f1c", 8'h1C, 1'b0, 1, 0, 8'h1C, -1);

        // Back-to-back break prefix then make code
        frame_check("ff0", 8'hF0, 1'b1, 1, 0, 8'hF0, -1);
        frame_check("f1c_b2b", 8'h1C, 1'b0, 1, 0, 8'h1C, -1);

        // Parity error keeps old data
        frame_check("par_err", 8'h1C, 1'b1, 0, 1, 8'h1C, -1);

        // Glitch while idle must not start anything
        c0 = comp_cnt;
        e0 = err_cnt;
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(4);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(HALF);
        chk("idle_glitch_complete", 32'(comp_cnt - c0), 32'h0);
        chk("idle_glitch_error",    32'(err_cnt - e0),  32'h0);
        // Glitch mid-frame after the third data bit
        frame_check("glitch_5a", 8'h5A, 1'b1, 1, 0, 8'h5A, 3);

        // Stalled frame: start + 3 data bits, then clock held high 250 us
        c0 = comp_cnt;
        e0 = err_cnt;
        send_bits(8'h5A, 1'b1, 4, -1);
        wait_cyc(25_000);
        chk("timeout_error",    32'(err_cnt - e0),  32'h1);
        chk("timeout_complete", 32'(comp_cnt - c0), 32'h0);
        chk("timeout_data",     32'(rx_data),       32'h5A);
        lat = err_cyc - last_fall;
        chk("timeout_latency_window", 32'((lat >= 20_000 && lat <= 20_030) ? 1 : 0), 32'h1);
        frame_check("after_to", 8'h5A, 1'b1, 1, 0, 8'h5A, -1);

        // Reset after 5 bits aborts silently
        c0 = comp_cnt;
        e0 = err_cnt;
        send_bits(8'h1C, 1'b0, 5, -1);
        resetn = 1'b0;
        wait_cyc(3);
        chk("midrst_data",     32'(rx_data),     32'h00);
        chk("midrst_complete", 32'(rx_complete), 32'h0);
        chk("midrst_error",    32'(rx_error),    32'h0);
        resetn = 1'b1;
        wait_cyc(25_000);
        chk("midrst_no_complete", 32'(comp_cnt - c0), 32'h0);
        chk("midrst_no_error",    32'(err_cnt - e0),  32'h0);
        frame_check("after_rst", 8'h1C, 1'b0, 1, 0, 8'h1C, -1);

        chk("never_both", 32'(both_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
